// File: rtl/test_pattern_gen.sv
// Video test-pattern source: two-stage pipeline from timing-generator strobes to registered RGB.
// Pattern, bar width and box position change only at frame start, so frames never tear.
module test_pattern_gen #(
    parameter int unsigned X_BITS   = 12,
    parameter int unsigned Y_BITS   = 12,
    parameter int unsigned BOX_SIZE = 64,
    parameter int unsigned BOX_STEP = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    input  logic [X_BITS-1:0] x_act,
    input  logic [Y_BITS-1:0] y_act,
    input  logic [X_BITS-1:0] h_act,
    input  logic [Y_BITS-1:0] v_act,
    input  logic [2:0]        pattern_sel,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out,
    output logic [7:0]        r_out,
    output logic [7:0]        g_out,
    output logic [7:0]        b_out,
    output logic [7:0]        frame_cnt
);

    localparam logic [X_BITS:0]   XMin   = (X_BITS+1)'(BOX_SIZE + BOX_STEP);
    localparam logic [X_BITS:0]   XSize  = (X_BITS+1)'(BOX_SIZE);
    localparam logic [X_BITS:0]   XStepW = (X_BITS+1)'(BOX_STEP);
    localparam logic [X_BITS-1:0] XStep  = X_BITS'(BOX_STEP);
    localparam logic [Y_BITS:0]   YMin   = (Y_BITS+1)'(BOX_SIZE + BOX_STEP);
    localparam logic [Y_BITS:0]   YSize  = (Y_BITS+1)'(BOX_SIZE);
    localparam logic [Y_BITS:0]   YStepW = (Y_BITS+1)'(BOX_STEP);
    localparam logic [Y_BITS-1:0] YStep  = Y_BITS'(BOX_STEP);

    logic              vs1_q, hs1_q, de1_q;
    logic [23:0]       rgb1_q, pixel_d, bar_rgb;
    logic [2:0]        pat_q;
    logic [X_BITS-1:0] bw_q, bw_d, bw_shift;
    logic [2:0]        bar_idx_q, bar_idx_d, cur_idx;
    logic [X_BITS-1:0] bar_cnt_q, bar_cnt_d, cur_cnt;
    logic [X_BITS-1:0] box_x_q, box_x_d;
    logic [Y_BITS-1:0] box_y_q, box_y_d;
    logic              dir_x_neg_q, dir_x_neg_d, dir_y_neg_q, dir_y_neg_d;
    logic              fs, line_start, in_box, grid;

    // Stage-1 copies of vs/de double as the edge-detect history.
    assign fs         = vs_in & ~vs1_q;
    assign line_start = de_in & ~de1_q;

    assign bw_shift = h_act >> 3;
    assign bw_d     = (bw_shift == '0) ? X_BITS'(1) : bw_shift;

    always_comb begin
        cur_idx   = line_start ? 3'd0 : bar_idx_q;
        cur_cnt   = line_start ? '0 : bar_cnt_q;
        bar_idx_d = bar_idx_q;
        bar_cnt_d = bar_cnt_q;
        if (de_in) begin
            if (cur_cnt == bw_q - 1'b1 && cur_idx != 3'd7) begin
                bar_idx_d = cur_idx + 3'd1;
                bar_cnt_d = '0;
            end else begin
                bar_idx_d = cur_idx;
                bar_cnt_d = cur_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        case (cur_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    assign grid = (x_act[5:0] == 6'd0) || (y_act[5:0] == 6'd0) ||
                  (x_act == h_act - 1'b1) || (y_act == v_act - 1'b1);

    assign in_box = ({1'b0, x_act} >= {1'b0, box_x_q}) && ({1'b0, x_act} < {1'b0, box_x_q} + XSize) &&
                    ({1'b0, y_act} >= {1'b0, box_y_q}) && ({1'b0, y_act} < {1'b0, box_y_q} + YSize);

    always_comb begin
        case (pat_q)
            3'd0:    pixel_d = bar_rgb;
            3'd1:    pixel_d = grid ? 24'hFFFFFF : 24'h000000;
            3'd2:    pixel_d = {3{x_act[7:0]}};
            3'd3:    pixel_d = in_box ? 24'hFFFFFF : 24'h0000FF;
            3'd4:    pixel_d = 24'h808080;
            default: pixel_d = 24'h000000;
        endcase
    end

    // Bounce: reverse one step early rather than overshoot the far edge.
    always_comb begin
        box_x_d     = box_x_q;
        dir_x_neg_d = dir_x_neg_q;
        if ({1'b0, h_act} < XMin) begin
            box_x_d = '0;
        end else if (!dir_x_neg_q) begin
            if ({1'b0, box_x_q} + XStepW > {1'b0, h_act} - XSize) begin
                dir_x_neg_d = 1'b1;
                box_x_d     = box_x_q - XStep;
            end else begin
                box_x_d = box_x_q + XStep;
            end
        end else if ({1'b0, box_x_q} < XStepW) begin
            dir_x_neg_d = 1'b0;
            box_x_d     = box_x_q + XStep;
        end else begin
            box_x_d = box_x_q - XStep;
        end
    end

    always_comb begin
        box_y_d     = box_y_q;
        dir_y_neg_d = dir_y_neg_q;
        if ({1'b0, v_act} < YMin) begin
            box_y_d = '0;
        end else if (!dir_y_neg_q) begin
            if ({1'b0, box_y_q} + YStepW > {1'b0, v_act} - YSize) begin
                dir_y_neg_d = 1'b1;
                box_y_d     = box_y_q - YStep;
            end else begin
                box_y_d = box_y_q + YStep;
            end
        end else if ({1'b0, box_y_q} < YStepW) begin
            dir_y_neg_d = 1'b0;
            box_y_d     = box_y_q + YStep;
        end else begin
            box_y_d = box_y_q - YStep;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs1_q       <= 1'b0;
            hs1_q       <= 1'b0;
            de1_q       <= 1'b0;
            rgb1_q      <= '0;
            vs_out      <= 1'b0;
            hs_out      <= 1'b0;
            de_out      <= 1'b0;
            r_out       <= '0;
            g_out       <= '0;
            b_out       <= '0;
            frame_cnt   <= '0;
            pat_q       <= '0;
            bw_q        <= X_BITS'(1);
            bar_idx_q   <= '0;
            bar_cnt_q   <= '0;
            box_x_q     <= '0;
            box_y_q     <= '0;
            dir_x_neg_q <= 1'b0;
            dir_y_neg_q <= 1'b0;
        end else begin
            vs1_q     <= vs_in;
            hs1_q     <= hs_in;
            de1_q     <= de_in;
            rgb1_q    <= pixel_d;
            vs_out    <= vs1_q;
            hs_out    <= hs1_q;
            de_out    <= de1_q;
            {r_out, g_out, b_out} <= de1_q ? rgb1_q : 24'h000000;
            bar_idx_q <= bar_idx_d;
            bar_cnt_q <= bar_cnt_d;
            if (fs) begin
                pat_q       <= pattern_sel;
                bw_q        <= bw_d;
                frame_cnt   <= frame_cnt + 8'd1;
                box_x_q     <= box_x_d;
                box_y_q     <= box_y_d;
                dir_x_neg_q <= dir_x_neg_d;
                dir_y_neg_q <= dir_y_neg_d;
            end
        end
    end

endmodule
